load_buffer: RTL and testbench

// - In-order FIFO of address-resolved loads between the address unit and the memory controller.
// - Takes loads issued by the RS through the address unit and performs one memory read at a time.
// - Sign- or zero-extends each result and broadcasts it on the CDB load channel.
// - Drives lbuffer_rs_rdy so the RS issues a load only when a slot is guaranteed.

---
 rtl/load_buffer_pkg.sv | 33 +++
 rtl/load_buffer_extend.sv | 40 ++++
 rtl/load_buffer.sv | 139 +++++++++++++
 tb/tb_load_buffer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_buffer_pkg.sv
// Shared widths, opcode encodings and types for the load buffer.
// Opcodes LB..LHU are contiguous; size codes match the memory controller.
package load_buffer_pkg;

  localparam int IDWidth       = 32;
  localparam int ROBWidth      = 4;
  localparam int AddressWidth  = 32;
  localparam int InstTypeWidth = 6;
  localparam int LBCount       = 8;

  localparam logic [InstTypeWidth-1:0] LB  = 6'd10;
  localparam logic [InstTypeWidth-1:0] LH  = 6'd11;
  localparam logic [InstTypeWidth-1:0] LW  = 6'd12;
  localparam logic [InstTypeWidth-1:0] LBU = 6'd13;
  localparam logic [InstTypeWidth-1:0] LHU = 6'd14;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } lb_state_e;

  typedef struct packed {
    logic [AddressWidth-1:0]  addr;
    logic [ROBWidth-1:0]      dest;
    logic [InstTypeWidth-1:0] opcode;
  } lb_entry_t;

endpackage

// File: rtl/load_buffer_extend.sv
// Load result extension and access-size decode.
// Unknown opcodes fall back to a word access with data passed through.
module load_extend
  import load_buffer_pkg::*;
(
  input  logic [InstTypeWidth-1:0] opcode,
  input  logic [IDWidth-1:0]       data,
  output logic [IDWidth-1:0]       result,
  output logic [1:0]               size
);

  always_comb begin
    result = data;
    size   = SZ_W;
    unique case (1'b1)
      opcode == LB: begin
        result = {{(IDWidth-8){data[7]}}, data[7:0]};
        size   = SZ_B;
      end
      opcode == LH: begin
        result = {{(IDWidth-16){data[15]}}, data[15:0]};
        size   = SZ_H;
      end
      opcode == LBU: begin
        result = {{(IDWidth-8){1'b0}}, data[7:0]};
        size   = SZ_B;
      end
      opcode == LHU: begin
        result = {{(IDWidth-16){1'b0}}, data[15:0]};
        size   = SZ_H;
      end
      opcode == LW: begin
        result = data;
        size   = SZ_W;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_buffer.sv
// In-order load queue: one outstanding memory read, extended CDB broadcast.
// A flush while a read is in flight drains that read without broadcasting.
module load_buffer
  import load_buffer_pkg::*;
#(
  parameter int DEPTH = LBCount,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     rob_lbuffer_rst_in,
  input  logic                     addrunit_lbuffer_en_in,
  input  logic [AddressWidth-1:0]  addrunit_lbuffer_addr_in,
  input  logic [ROBWidth-1:0]      addrunit_lbuffer_dest_in,
  input  logic [InstTypeWidth-1:0] addrunit_lbuffer_opcode_in,
  output logic                     lbuffer_rs_rdy_out,
  output logic                     lbuffer_memctrl_req_out,
  output logic [AddressWidth-1:0]  lbuffer_memctrl_addr_out,
  output logic [1:0]               lbuffer_memctrl_size_out,
  input  logic                     memctrl_lbuffer_done_in,
  input  logic [IDWidth-1:0]       memctrl_lbuffer_data_in,
  output logic [ROBWidth-1:0]      lbuffer_cdb_b_out,
  output logic [IDWidth-1:0]       lbuffer_cdb_result_out
);

  lb_entry_t        mem_q [DEPTH];
  lb_entry_t        head;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;
  lb_state_e        state_q;
  lb_state_e        state_d;

  logic               flush;
  logic               full;
  logic               enq;
  logic               pop;
  logic               done;
  logic [IDWidth-1:0] ext_res;
  logic [1:0]         head_size;

  assign flush = rob_lbuffer_rst_in;
  assign done  = memctrl_lbuffer_done_in;
  assign head  = mem_q[head_q];
  assign full  = count_q == (PTR_W+1)'(DEPTH);
  assign enq   = addrunit_lbuffer_en_in && !full;
  assign pop   = (state_q == WAIT) && done;

  // One spare slot covers a load the RS launched before seeing rdy drop.
  assign lbuffer_rs_rdy_out =
    count_q <= (PTR_W+1)'(DEPTH-2);

  load_extend u_ext (
    .opcode (head.opcode),
    .data   (memctrl_lbuffer_data_in),
    .result (ext_res),
    .size   (head_size)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (!flush && count_q != '0)
          state_d = WAIT;
      WAIT:
        if (done)       state_d = IDLE;
        else if (flush) state_d = DRAIN;
      DRAIN:
        if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     state_q <= IDLE;
    else if (rdy_in) state_q <= state_d;
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush && enq)
      mem_q[tail_q] <= '{
        addr:   addrunit_lbuffer_addr_in,
        dest:   addrunit_lbuffer_dest_in,
        opcode: addrunit_lbuffer_opcode_in
      };
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (enq) tail_q <= tail_q + 1'b1;
        if (pop) head_q <= head_q + 1'b1;
        count_q <= count_q
                 + (PTR_W+1)'(enq)
                 - (PTR_W+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      lbuffer_memctrl_req_out  <= 1'b0;
      lbuffer_memctrl_addr_out <= '0;
      lbuffer_memctrl_size_out <= '0;
      lbuffer_cdb_b_out        <= '0;
      lbuffer_cdb_result_out   <= '0;
    end else if (rdy_in) begin
      lbuffer_cdb_b_out <= '0;
      if (state_q == IDLE && state_d == WAIT) begin
        lbuffer_memctrl_req_out  <= 1'b1;
        lbuffer_memctrl_addr_out <= head.addr;
        lbuffer_memctrl_size_out <= head_size;
      end
      if (state_q != IDLE && state_d == IDLE)
        lbuffer_memctrl_req_out <= 1'b0;
      // A read completing on the flush cycle belongs to a squashed load.
      if (pop && !flush) begin
        lbuffer_cdb_b_out      <= head.dest;
        lbuffer_cdb_result_out <= ext_res;
      end
    end
  end

  full_enq_a: assert property (
    @(posedge clk_in) disable iff (!rst_in)
    !(rdy_in && !flush && addrunit_lbuffer_en_in && full)
  ) else $warning("load_buffer: enqueue while full dropped");

endmodule

// File: tb/tb_load_buffer.sv
// Directed bench for load_buffer with a queue-level reference model.
// The bench acts as address unit, ROB and memory controller.
module tb_load_buffer;
  import load_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        en = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  dest = '0;
  logic [5:0]  op = '0;
  logic        done = 1'b0;
  logic [31:0] data = '0;

  logic        rs_rdy;
  logic        req;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [3:0]  cdb_b;
  logic [31:0] cdb_r;

  load_buffer dut (
    .clk_in                     (clk),
    .rst_in                     (rst_n),
    .rdy_in                     (rdy),
    .rob_lbuffer_rst_in         (flush),
    .addrunit_lbuffer_en_in     (en),
    .addrunit_lbuffer_addr_in   (addr),
    .addrunit_lbuffer_dest_in   (dest),
    .addrunit_lbuffer_opcode_in (op),
    .lbuffer_rs_rdy_out         (rs_rdy),
    .lbuffer_memctrl_req_out    (req),
    .lbuffer_memctrl_addr_out   (req_addr),
    .lbuffer_memctrl_size_out   (req_size),
    .memctrl_lbuffer_done_in    (done),
    .memctrl_lbuffer_data_in    (data),
    .lbuffer_cdb_b_out          (cdb_b),
    .lbuffer_cdb_result_out     (cdb_r)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] szf(input logic [5:0] o);
    if (o == LB || o == LBU) return 2'd0;
    if (o == LH || o == LHU) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] extf(input logic [5:0] o,
                                       input logic [31:0] d);
    case (o)
      LB:  return d[7] ? (32'hFFFF_FF00 | {24'h0, d[7:0]})
                       : {24'h0, d[7:0]};
      LH:  return d[15] ? (32'hFFFF_0000 | {16'h0, d[15:0]})
                        : {16'h0, d[15:0]};
      LBU: return {24'h0, d[7:0]};
      LHU: return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [3:0]  d;
    logic [5:0]  o;
  } ld_t;

  ld_t         q[$];
  logic [3:0]  exp_b = '0;
  logic [31:0] exp_r = '0;
  bit          mflight = 0;
  bit          stale = 0;
  bit          live = 0;

  // Reference: FIFO of accepted loads; each done retires the oldest
  // unless the read in flight was squashed by a flush.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      exp_b = '0;
      exp_r = '0;
      mflight = 0;
      stale = 0;
    end else if (rdy) begin
      int n;
      n = q.size();
      exp_b = '0;
      if (flush) begin
        q.delete();
        if (done) begin
          mflight = 0;
          stale = 0;
        end else if (mflight) begin
          stale = 1;
        end
      end else begin
        if (done) begin
          if (stale) stale = 0;
          else if (q.size() > 0) begin
            exp_b = q[0].d;
            exp_r = extf(q[0].o, data);
            void'(q.pop_front());
          end
          mflight = 0;
        end
        if (en && n < 8)
          q.push_back('{a: addr, d: dest, o: op});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && live) begin
      chk("cdb_b", 32'(cdb_b), 32'(exp_b));
      if (exp_b != '0)
        chk("cdb_result", cdb_r, exp_r);
      chk("rs_rdy", 32'(rs_rdy), 32'(q.size() <= 6));
    end
  end

  task automatic enq(input logic [5:0] o,
                     input logic [3:0] d,
                     input logic [31:0] a);
    en = 1'b1; op = o; dest = d; addr = a;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic get_req();
    bit got;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL req_timeout got=0 want=1 t=%0t", $time);
    end else if (!stale && q.size() > 0) begin
      chk("req_addr", req_addr, q[0].a);
      chk("req_size", 32'(req_size), 32'(szf(q[0].o)));
    end
    mflight = 1;
  endtask

  task automatic serve(input logic [31:0] d, input int dly);
    get_req();
    repeat (dly) begin
      @(negedge clk);
      chk("req_hold", 32'(req), 32'd1);
    end
    done = 1'b1; data = d;
    @(negedge clk);
    done = 1'b0; data = '0;
  endtask

  logic [5:0] ops [5];

  function automatic logic [31:0] mkdata(input logic [5:0] o,
                                         input int i);
    if (szf(o) == 2'd0) return 32'h80 | 32'(i);
    if (szf(o) == 2'd1) return 32'h8000 | 32'(i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  initial begin
    ops = '{LB, LH, LW, LBU, LHU};
    #3 rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", req_addr, 32'd0);
    chk("rst_size", 32'(req_size), 32'd0);
    chk("rst_cdb_b", 32'(cdb_b), 32'd0);
    chk("rst_cdb_r", cdb_r, 32'd0);
    chk("rst_rs_rdy", 32'(rs_rdy), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    live = 1;
    @(negedge clk);

    enq(LB, 4'd3, 32'h100);
    serve(32'h80, 0);
    chk("lb_tag", 32'(cdb_b), 32'd3);
    chk("lb_val", cdb_r, 32'hFFFF_FF80);
    @(negedge clk);
    chk("lb_oneshot", 32'(cdb_b), 32'd0);

    enq(LBU, 4'd3, 32'h100);
    serve(32'h80, 1);
    chk("lbu_val", cdb_r, 32'h0000_0080);

    for (int i = 0; i < 8; i++) begin
      en = 1'b1;
      addr = 32'h500 + 32'(4 * i);
      dest = 4'(i + 1);
      op = ops[i % 5];
      @(negedge clk);
      if (i == 5) chk("rdy_at6", 32'(rs_rdy), 32'd1);
      if (i == 6) chk("rdy_at7", 32'(rs_rdy), 32'd0);
      if (i == 7) chk("rdy_at8", 32'(rs_rdy), 32'd0);
    end
    addr = 32'h5F0; dest = 4'd15; op = LW;
    @(negedge clk);
    en = 1'b0;
    chk("q_len_full", 32'(q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      serve(mkdata(ops[i % 5], i), i % 3);
      if (i == 0) begin
        chk("full_first_tag", 32'(cdb_b), 32'd1);
        chk("full_first_val", cdb_r, 32'hFFFF_FF80);
      end
    end
    repeat (4) begin
      @(negedge clk);
      chk("ninth_dropped", 32'(req), 32'd0);
    end

    enq(LW, 4'd5, 32'h200);
    get_req();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    en = 1'b1; op = LH; dest = 4'd6; addr = 32'h204;
    @(negedge clk);
    en = 1'b0;
    chk("drain_req", 32'(req), 32'd1);
    chk("drain_addr", req_addr, 32'h200);
    @(negedge clk);
    done = 1'b1; data = 32'hDEAD;
    @(negedge clk);
    done = 1'b0; data = '0;
    chk("drain_no_bcast", 32'(cdb_b), 32'd0);
    serve(32'h8001, 0);
    chk("post_flush_tag", 32'(cdb_b), 32'd6);
    chk("post_flush_val", cdb_r, 32'hFFFF_8001);

    enq(LW, 4'd7, 32'h300);
    get_req();
    rdy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("stall_req", 32'(req), 32'd1);
      chk("stall_addr", req_addr, 32'h300);
    end
    rdy = 1'b1;
    done = 1'b1; data = 32'h1234_5678;
    @(negedge clk);
    done = 1'b0; data = '0;
    chk("stall_tag", 32'(cdb_b), 32'd7);
    chk("stall_val", cdb_r, 32'h1234_5678);

    enq(LW, 4'd8, 32'h400);
    get_req();
    done = 1'b1; data = 32'hCAFE_F00D;
    en = 1'b1; op = LHU; dest = 4'd9; addr = 32'h402;
    @(negedge clk);
    done = 1'b0; data = '0; en = 1'b0;
    chk("swap_tag", 32'(cdb_b), 32'd8);
    chk("swap_val", cdb_r, 32'hCAFE_F00D);
    chk("swap_len", 32'(q.size()), 32'd1);
    serve(32'h0000_BEEF, 1);
    chk("lhu_tag", 32'(cdb_b), 32'd9);
    chk("lhu_val", cdb_r, 32'h0000_BEEF);

    enq(LW, 4'd10, 32'h600);
    enq(LW, 4'd11, 32'h604);
    enq(LW, 4'd12, 32'h608);
    get_req();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(req), 32'd0);
    chk("arst_cdb_b", 32'(cdb_b), 32'd0);
    chk("arst_rs_rdy", 32'(rs_rdy), 32'd1);
    #2 rst_n = 1'b1;
    mflight = 0;
    repeat (4) begin
      @(negedge clk);
      chk("arst_empty", 32'(req), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
